asym_ram_fifo_ctrl: RTL and testbench
=====================================

// Module: asym_ram_fifo_ctrl
// PURPOSE
//  FIFO controller that sequences the external two-port asymmetric RAM (byte-addressed, registered read) as a width-converting FIFO.
//  Generates byte write/read addresses and enables, and tracks occupancy in bytes.
//  Provides full/empty flow control to a Versat producer unit (W_DATA_W) and consumer unit (R_DATA_W).
//  Contains no storage itself; sits between the unit datapath and the RAM instance.
// PARAMETERS
//  W_DATA_W  32  write word width, bits; multiple of 8, power of 2
//  R_DATA_W  8   read word width, bits; multiple of 8, power of 2; max(W,R)/min(W,R) is a power of 2
//  ADDR_W    10  RAM byte-address width; capacity 2^ADDR_W bytes; 2^ADDR_W >= 2*max(W,R)/8
// PORTS
//  clk_i         in   1           clock, all logic on rising edge
//  rst_i         in   1           synchronous active-high reset
//  clear_i       in   1           synchronous flush (pointers/level to 0)
//  w_en_i        in   1           write request
//  w_data_i      in   W_DATA_W    write word
//  w_full_o      out  1           write would overflow; w_en_i ignored while 1
//  r_en_i        in   1           read request
//  r_data_o      out  R_DATA_W    read word, valid when r_valid_o=1
//  r_valid_o     out  1           pulses 1 cycle after an accepted read
//  r_empty_o     out  1           fewer than R_DATA_W/8 bytes stored; r_en_i ignored while 1
//  level_o       out  ADDR_W+1    stored bytes, 0..2^ADDR_W
//  ram_w_en_o    out  1           RAM write enable
//  ram_w_addr_o  out  ADDR_W      RAM byte write address
//  ram_w_data_o  out  W_DATA_W    RAM write data
//  ram_r_en_o    out  1           RAM read enable
//  ram_r_addr_o  out  ADDR_W      RAM byte read address
//  ram_r_data_i  in   R_DATA_W    RAM read data, 1-cycle latency after ram_r_en_o
// BEHAVIOUR
//  Constants: WB = W_DATA_W/8 and RB = R_DATA_W/8 bytes per access.
//  State: wptr and rptr, ADDR_W+1 bits each (MSB is the wrap bit); level register.
//  Reset (rst_i=1), values next cycle:
//   wptr=rptr=0, level_o=0, r_empty_o=1, w_full_o=0, r_valid_o=0.
//  Flow-control flags, registered from level:
//   w_full_o  = (2^ADDR_W - level) < WB
//   r_empty_o = level < RB
//  Accept rules:
//   w_acc = w_en_i & ~w_full_o
//   r_acc = r_en_i & ~r_empty_o
//   Both evaluated against current-cycle flags.
//  RAM drive (combinational):
//   ram_w_en_o=w_acc, ram_w_addr_o=wptr[ADDR_W-1:0], ram_w_data_o=w_data_i
//   ram_r_en_o=r_acc, ram_r_addr_o=rptr[ADDR_W-1:0]
//  Pointer/level update on the rising edge:
//   w_acc: wptr += WB.
//   r_acc: rptr += RB.
//   level += (w_acc?WB:0) - (r_acc?RB:0).
//   Simultaneous accept applies both in the same edge; level stays in 0..2^ADDR_W.
//  Wrap-around: pointers wrap modulo 2^(ADDR_W+1); the address is the low ADDR_W bits, so it wraps to 0 after the top word.
//  Read latency: r_valid_o=1 exactly one cycle after r_acc; r_data_o=ram_r_data_i (pass-through).
//   Back-to-back r_acc gives one word per cycle.
//  Byte order is little-endian:
//   W>R: word w_data_i is read back as W/R reads, LSB slice first.
//   W<R: the first written word lands in r_data_o[W_DATA_W-1:0].
//  Read-during-write: a read may only target bytes counted in level at the start of the cycle.
//   Bytes written in cycle t are readable from cycle t+1; no RAM bypass is required.
//  clear_i=1: same effect as reset on wptr, rptr, level and flags.
//   Overrides w_en_i/r_en_i that cycle: ram_w_en_o=ram_r_en_o=0.
//   r_valid_o for a read accepted in the previous cycle still pulses.
//  rst_i has priority over clear_i.
// TESTING
//  W=32,R=8,ADDR_W=4: write 0x44332211 -> four reads return 11,22,33,44; r_valid_o pulses each cycle after r_en_i; level_o 4,3,2,1,0 bytes.
//  W=32,R=8,ADDR_W=4: 4 writes, no reads -> level_o=16, w_full_o=1; 5th write ignored (ram_w_en_o=0); one read -> level 15, w_full_o stays 1 (1<4).
//  W=8,R=32,ADDR_W=4: writes AA,BB,CC -> r_empty_o=1; 4th write DD -> r_empty_o=0 next cycle; read returns 0xDDCCBBAA.
//  Wrap test (W=32,R=8,ADDR_W=4): run 40 writes/160 reads with a random enable mix -> ram_w_addr_o sequence 0,4,8,12,0,...; data order preserved; level never >16 or <0.
//  Simultaneous w_acc+r_acc at level 8 -> level 8+4-1=11 next cycle, both RAM enables high that cycle.
//  clear_i pulse at level 9 with w_en_i=r_en_i=1 -> RAM enables 0; level_o=0, r_empty_o=1 next cycle; rst_i mid-stream gives the same result.

Source files
------------

// File: rtl/asym_ram_fifo_ctrl.sv
// Width-converting FIFO controller for an external byte-addressed two-port RAM
// with registered read; owns the pointers, the byte level and the flow-control flags.
module asym_ram_fifo_ctrl #(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                w_en_i,
    input  logic [W_DATA_W-1:0] w_data_i,
    output logic                w_full_o,
    input  logic                r_en_i,
    output logic [R_DATA_W-1:0] r_data_o,
    output logic                r_valid_o,
    output logic                r_empty_o,
    output logic [ADDR_W:0]     level_o,
    output logic                ram_w_en_o,
    output logic [ADDR_W-1:0]   ram_w_addr_o,
    output logic [W_DATA_W-1:0] ram_w_data_o,
    output logic                ram_r_en_o,
    output logic [ADDR_W-1:0]   ram_r_addr_o,
    input  logic [R_DATA_W-1:0] ram_r_data_i
);

    localparam int WB = W_DATA_W / 8;
    localparam int RB = R_DATA_W / 8;

    localparam logic [ADDR_W:0] WB_INC = (ADDR_W + 1)'(WB);
    localparam logic [ADDR_W:0] RB_INC = (ADDR_W + 1)'(RB);
    localparam logic [ADDR_W:0] CAP    = (ADDR_W + 1)'(1) << ADDR_W;

    logic [ADDR_W:0] wptr;
    logic [ADDR_W:0] rptr;
    logic [ADDR_W:0] level;
    logic [ADDR_W:0] level_nxt;
    logic            w_full;
    logic            r_empty;
    logic            r_valid;
    logic            w_acc;
    logic            r_acc;

    // Flush and reset both suppress any transfer in the cycle they are asserted.
    always_comb begin
        w_acc     = w_en_i & ~w_full & ~clear_i & ~rst_i;
        r_acc     = r_en_i & ~r_empty & ~clear_i & ~rst_i;
        level_nxt = level;
        if (w_acc) level_nxt = level_nxt + WB_INC;
        if (r_acc) level_nxt = level_nxt - RB_INC;
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i || clear_i) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            w_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_acc) wptr <= wptr + WB_INC;
            if (r_acc) rptr <= rptr + RB_INC;
            level   <= level_nxt;
            // Flags are computed from the next level so they always agree with level_o.
            w_full  <= (CAP - level_nxt) < WB_INC;
            r_empty <= level_nxt < RB_INC;
        end
    end

    // A read accepted just before a flush still reports its data; r_acc is already 0 under rst/clear.
    always_ff @(posedge clk_i) begin
        r_valid <= r_acc;
    end

    assign w_full_o     = w_full;
    assign r_empty_o    = r_empty;
    assign r_valid_o    = r_valid;
    assign level_o      = level;
    assign r_data_o     = ram_r_data_i;

    assign ram_w_en_o   = w_acc;
    assign ram_w_addr_o = wptr[ADDR_W-1:0];
    assign ram_w_data_o = w_data_i;
    assign ram_r_en_o   = r_acc;
    assign ram_r_addr_o = rptr[ADDR_W-1:0];

endmodule

// File: tb/tb_asym_ram_fifo_ctrl.sv
// Directed bench for asym_ram_fifo_ctrl: a 32->8 instance (a_*) and an 8->32 instance (b_*),
// each backed by a small behavioural byte-addressed RAM with registered read.
module tb_asym_ram_fifo_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- instance A: W=32, R=8, ADDR_W=4 ----------------
    logic        a_rst, a_clr, a_wen, a_ren;
    logic [31:0] a_wdata;
    logic        a_wfull, a_rvalid, a_empty;
    logic [7:0]  a_rdata;
    logic [4:0]  a_level;
    logic        a_ram_wen, a_ram_ren;
    logic [3:0]  a_ram_waddr, a_ram_raddr;
    logic [31:0] a_ram_wdata;
    logic [7:0]  a_ram_rdata;
    logic [7:0]  mem_a [16];

    asym_ram_fifo_ctrl #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) dut_a (
        .clk_i(clk), .rst_i(a_rst), .clear_i(a_clr),
        .w_en_i(a_wen), .w_data_i(a_wdata), .w_full_o(a_wfull),
        .r_en_i(a_ren), .r_data_o(a_rdata), .r_valid_o(a_rvalid), .r_empty_o(a_empty),
        .level_o(a_level),
        .ram_w_en_o(a_ram_wen), .ram_w_addr_o(a_ram_waddr), .ram_w_data_o(a_ram_wdata),
        .ram_r_en_o(a_ram_ren), .ram_r_addr_o(a_ram_raddr), .ram_r_data_i(a_ram_rdata)
    );

    always @(posedge clk) begin
        if (a_ram_wen)
            for (int k = 0; k < 4; k++) mem_a[a_ram_waddr + 4'(k)] <= a_ram_wdata[8*k +: 8];
        if (a_ram_ren) a_ram_rdata <= mem_a[a_ram_raddr];
    end

    // ---------------- instance B: W=8, R=32, ADDR_W=4 ----------------
    logic        b_rst, b_clr, b_wen, b_ren;
    logic [7:0]  b_wdata;
    logic        b_wfull, b_rvalid, b_empty;
    logic [31:0] b_rdata;
    logic [4:0]  b_level;
    logic        b_ram_wen, b_ram_ren;
    logic [3:0]  b_ram_waddr, b_ram_raddr;
    logic [7:0]  b_ram_wdata;
    logic [31:0] b_ram_rdata;
    logic [7:0]  mem_b [16];

    asym_ram_fifo_ctrl #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) dut_b (
        .clk_i(clk), .rst_i(b_rst), .clear_i(b_clr),
        .w_en_i(b_wen), .w_data_i(b_wdata), .w_full_o(b_wfull),
        .r_en_i(b_ren), .r_data_o(b_rdata), .r_valid_o(b_rvalid), .r_empty_o(b_empty),
        .level_o(b_level),
        .ram_w_en_o(b_ram_wen), .ram_w_addr_o(b_ram_waddr), .ram_w_data_o(b_ram_wdata),
        .ram_r_en_o(b_ram_ren), .ram_r_addr_o(b_ram_raddr), .ram_r_data_i(b_ram_rdata)
    );

    always @(posedge clk) begin
        if (b_ram_wen) mem_b[b_ram_waddr] <= b_ram_wdata;
        if (b_ram_ren)
            b_ram_rdata <= {mem_b[b_ram_raddr + 4'd3], mem_b[b_ram_raddr + 4'd2],
                            mem_b[b_ram_raddr + 4'd1], mem_b[b_ram_raddr]};
    end

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        a_wen = 1'b1; a_wdata = 32'hDEADBEEF;
        cyc(); cyc();
        a_rst = 1'b0; b_rst = 1'b0; a_wen = 1'b0;
        n_checks++; if (a_level !== 5'd0) $display("FAIL rst_level_a: got %0d expected 0", a_level); else n_pass++;
        n_checks++; if (a_empty !== 1'b1) $display("FAIL rst_empty_a: got %b expected 1", a_empty); else n_pass++;
        n_checks++; if (a_wfull !== 1'b0) $display("FAIL rst_full_a: got %b expected 0", a_wfull); else n_pass++;
        n_checks++; if (a_rvalid !== 1'b0) $display("FAIL rst_rvalid_a: got %b expected 0", a_rvalid); else n_pass++;
        n_checks++; if (b_level !== 5'd0) $display("FAIL rst_level_b: got %0d expected 0", b_level); else n_pass++;
        n_checks++; if (b_empty !== 1'b1) $display("FAIL rst_empty_b: got %b expected 1", b_empty); else n_pass++;
    endtask

    task automatic test_byte_order();
        logic [31:0] word;
        word = 32'h44332211;
        a_wen = 1'b1; a_wdata = word; #1;
        n_checks++; if (a_ram_wen !== 1'b1) $display("FAIL bo_ram_wen: got %b expected 1", a_ram_wen); else n_pass++;
        n_checks++; if (a_ram_waddr !== 4'd0) $display("FAIL bo_waddr: got %0d expected 0", a_ram_waddr); else n_pass++;
        cyc();
        a_wen = 1'b0;
        n_checks++; if (a_level !== 5'd4) $display("FAIL bo_level_w: got %0d expected 4", a_level); else n_pass++;
        n_checks++; if (a_empty !== 1'b0) $display("FAIL bo_empty_w: got %b expected 0", a_empty); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            a_ren = 1'b1; #1;
            n_checks++; if (a_ram_raddr !== 4'(i)) $display("FAIL bo_raddr%0d: got %0d expected %0d", i, a_ram_raddr, i); else n_pass++;
            cyc();
            n_checks++; if (a_rvalid !== 1'b1) $display("FAIL bo_rvalid%0d: got %b expected 1", i, a_rvalid); else n_pass++;
            n_checks++; if (a_rdata !== word[8*i +: 8]) $display("FAIL bo_rdata%0d: got %h expected %h", i, a_rdata, word[8*i +: 8]); else n_pass++;
            n_checks++; if (a_level !== 5'(3 - i)) $display("FAIL bo_level%0d: got %0d expected %0d", i, a_level, 3 - i); else n_pass++;
        end
        a_ren = 1'b1; #1;
        n_checks++; if (a_ram_ren !== 1'b0) $display("FAIL bo_read_empty: got %b expected 0", a_ram_ren); else n_pass++;
        cyc();
        a_ren = 1'b0;
        n_checks++; if (a_rvalid !== 1'b0) $display("FAIL bo_rvalid_idle: got %b expected 0", a_rvalid); else n_pass++;
        n_checks++; if (a_empty !== 1'b1) $display("FAIL bo_empty_end: got %b expected 1", a_empty); else n_pass++;
    endtask

    task automatic test_full();
        logic [31:0] words [4];
        logic [31:0] w;
        words[0] = 32'hA3A2A1A0; words[1] = 32'hB3B2B1B0;
        words[2] = 32'hC3C2C1C0; words[3] = 32'hD3D2D1D0;
        // Pointers sit at byte 4 after the previous test, so addresses wrap 4,8,12,0.
        for (int i = 0; i < 4; i++) begin
            a_wen = 1'b1; a_wdata = words[i]; #1;
            n_checks++; if (a_ram_waddr !== 4'((4 * i + 4) % 16)) $display("FAIL full_waddr%0d: got %0d expected %0d", i, a_ram_waddr, (4 * i + 4) % 16); else n_pass++;
            cyc();
        end
        n_checks++; if (a_level !== 5'd16) $display("FAIL full_level: got %0d expected 16", a_level); else n_pass++;
        n_checks++; if (a_wfull !== 1'b1) $display("FAIL full_flag: got %b expected 1", a_wfull); else n_pass++;
        a_wdata = 32'hEEEEEEEE; #1;
        n_checks++; if (a_ram_wen !== 1'b0) $display("FAIL full_5th_wen: got %b expected 0", a_ram_wen); else n_pass++;
        cyc();
        a_wen = 1'b0;
        n_checks++; if (a_level !== 5'd16) $display("FAIL full_5th_level: got %0d expected 16", a_level); else n_pass++;
        for (int j = 0; j < 16; j++) begin
            a_ren = 1'b1;
            cyc();
            w = words[j / 4];
            n_checks++; if (a_rvalid !== 1'b1) $display("FAIL full_rvalid%0d: got %b expected 1", j, a_rvalid); else n_pass++;
            n_checks++; if (a_rdata !== w[8*(j%4) +: 8]) $display("FAIL full_rdata%0d: got %h expected %h", j, a_rdata, w[8*(j%4) +: 8]); else n_pass++;
            if (j == 0) begin
                n_checks++; if (a_level !== 5'd15) $display("FAIL full_level15: got %0d expected 15", a_level); else n_pass++;
                n_checks++; if (a_wfull !== 1'b1) $display("FAIL full_stays: got %b expected 1", a_wfull); else n_pass++;
            end
            if (j == 12) begin
                n_checks++; if (a_wfull !== 1'b0) $display("FAIL full_release: got %b expected 0", a_wfull); else n_pass++;
            end
        end
        a_ren = 1'b0;
        cyc();
        n_checks++; if (a_level !== 5'd0) $display("FAIL full_drained: got %0d expected 0", a_level); else n_pass++;
    endtask

    task automatic test_simultaneous_and_clear();
        a_wen = 1'b1; a_wdata = 32'h01010101; cyc();
        a_wdata = 32'h02020202; cyc();
        n_checks++; if (a_level !== 5'd8) $display("FAIL sim_level8: got %0d expected 8", a_level); else n_pass++;
        a_wdata = 32'h03030303; a_ren = 1'b1; #1;
        n_checks++; if (a_ram_wen !== 1'b1) $display("FAIL sim_wen: got %b expected 1", a_ram_wen); else n_pass++;
        n_checks++; if (a_ram_ren !== 1'b1) $display("FAIL sim_ren: got %b expected 1", a_ram_ren); else n_pass++;
        cyc();
        n_checks++; if (a_level !== 5'd11) $display("FAIL sim_level11: got %0d expected 11", a_level); else n_pass++;
        a_wen = 1'b0; cyc(); cyc();
        n_checks++; if (a_level !== 5'd9) $display("FAIL clr_level9: got %0d expected 9", a_level); else n_pass++;
        a_clr = 1'b1; a_wen = 1'b1; a_ren = 1'b1; #1;
        n_checks++; if (a_ram_wen !== 1'b0) $display("FAIL clr_wen: got %b expected 0", a_ram_wen); else n_pass++;
        n_checks++; if (a_ram_ren !== 1'b0) $display("FAIL clr_ren: got %b expected 0", a_ram_ren); else n_pass++;
        n_checks++; if (a_rvalid !== 1'b1) $display("FAIL clr_prev_rvalid: got %b expected 1", a_rvalid); else n_pass++;
        cyc();
        a_clr = 1'b0; a_wen = 1'b0; a_ren = 1'b0;
        n_checks++; if (a_level !== 5'd0) $display("FAIL clr_level: got %0d expected 0", a_level); else n_pass++;
        n_checks++; if (a_empty !== 1'b1) $display("FAIL clr_empty: got %b expected 1", a_empty); else n_pass++;
        n_checks++; if (a_rvalid !== 1'b0) $display("FAIL clr_rvalid: got %b expected 0", a_rvalid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        a_wen = 1'b1; a_wdata = 32'h11111111; #1;
        n_checks++; if (a_ram_waddr !== 4'd0) $display("FAIL rm_waddr0: got %0d expected 0", a_ram_waddr); else n_pass++;
        cyc();
        a_wdata = 32'h22222222; cyc();
        n_checks++; if (a_level !== 5'd8) $display("FAIL rm_level8: got %0d expected 8", a_level); else n_pass++;
        a_rst = 1'b1; a_ren = 1'b1; cyc();
        a_rst = 1'b0; a_wen = 1'b0; a_ren = 1'b0;
        n_checks++; if (a_level !== 5'd0) $display("FAIL rm_level: got %0d expected 0", a_level); else n_pass++;
        n_checks++; if (a_empty !== 1'b1) $display("FAIL rm_empty: got %b expected 1", a_empty); else n_pass++;
        n_checks++; if (a_wfull !== 1'b0) $display("FAIL rm_full: got %b expected 0", a_wfull); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0]  q [$];
        logic [7:0]  exp_b;
        logic [31:0] wd;
        int lvl, exp_waddr, nw, nr, cycles;
        bit wen, ren, aw, ar;
        lvl = 0; exp_waddr = 0; nw = 0; nr = 0; cycles = 0; exp_b = '0;
        while ((nw < 40 || nr < 160) && cycles < 3000) begin
            wen = (nw < 40) && ($urandom_range(0, 2) != 0);
            ren = ($urandom_range(0, 3) != 0);
            aw  = wen && ((16 - lvl) >= 4);
            ar  = ren && (lvl >= 1);
            wd  = $urandom;
            a_wen = wen; a_ren = ren; a_wdata = wd; #1;
            n_checks++; if (a_ram_wen !== aw) $display("FAIL wrap_wen c%0d: got %b expected %b", cycles, a_ram_wen, aw); else n_pass++;
            n_checks++; if (a_ram_ren !== ar) $display("FAIL wrap_ren c%0d: got %b expected %b", cycles, a_ram_ren, ar); else n_pass++;
            if (aw) begin
                n_checks++; if (a_ram_waddr !== 4'(exp_waddr)) $display("FAIL wrap_waddr c%0d: got %0d expected %0d", cycles, a_ram_waddr, exp_waddr); else n_pass++;
                for (int k = 0; k < 4; k++) q.push_back(wd[8*k +: 8]);
                exp_waddr = (exp_waddr + 4) % 16;
                nw++;
            end
            if (ar) begin
                exp_b = q.pop_front();
                nr++;
            end
            lvl = lvl + (aw ? 4 : 0) - (ar ? 1 : 0);
            cyc();
            n_checks++; if (a_rvalid !== ar) $display("FAIL wrap_rvalid c%0d: got %b expected %b", cycles, a_rvalid, ar); else n_pass++;
            if (ar) begin
                n_checks++; if (a_rdata !== exp_b) $display("FAIL wrap_rdata c%0d: got %h expected %h", cycles, a_rdata, exp_b); else n_pass++;
            end
            n_checks++; if (a_level !== 5'(lvl)) $display("FAIL wrap_level c%0d: got %0d expected %0d", cycles, a_level, lvl); else n_pass++;
            cycles++;
        end
        a_wen = 1'b0; a_ren = 1'b0;
        n_checks++; if (nw != 40 || nr != 160) $display("FAIL wrap_timeout: got %0d writes %0d reads expected 40 160", nw, nr); else n_pass++;
    endtask

    task automatic test_upsize();
        logic [7:0] bytes_in [4];
        bytes_in[0] = 8'hAA; bytes_in[1] = 8'hBB; bytes_in[2] = 8'hCC; bytes_in[3] = 8'hDD;
        for (int i = 0; i < 4; i++) begin
            b_wen = 1'b1; b_wdata = bytes_in[i];
            cyc();
            n_checks++; if (b_empty !== (i < 3)) $display("FAIL up_empty%0d: got %b expected %b", i, b_empty, (i < 3)); else n_pass++;
        end
        b_wen = 1'b0;
        n_checks++; if (b_level !== 5'd4) $display("FAIL up_level4: got %0d expected 4", b_level); else n_pass++;
        b_ren = 1'b1; #1;
        n_checks++; if (b_ram_ren !== 1'b1) $display("FAIL up_ren: got %b expected 1", b_ram_ren); else n_pass++;
        cyc();
        b_ren = 1'b0;
        n_checks++; if (b_rvalid !== 1'b1) $display("FAIL up_rvalid: got %b expected 1", b_rvalid); else n_pass++;
        n_checks++; if (b_rdata !== 32'hDDCCBBAA) $display("FAIL up_rdata: got %h expected ddccbbaa", b_rdata); else n_pass++;
        n_checks++; if (b_level !== 5'd0) $display("FAIL up_level0: got %0d expected 0", b_level); else n_pass++;
        n_checks++; if (b_empty !== 1'b1) $display("FAIL up_empty_end: got %b expected 1", b_empty); else n_pass++;
    endtask

    initial begin
        a_rst = 1'b1; a_clr = 1'b0; a_wen = 1'b0; a_ren = 1'b0; a_wdata = '0;
        b_rst = 1'b1; b_clr = 1'b0; b_wen = 1'b0; b_ren = 1'b0; b_wdata = '0;
        test_reset();
        test_byte_order();
        test_full();
        test_simultaneous_and_clear();
        test_reset_mid();
        test_wrap();
        test_upsize();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
